// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: FSM state type, opcode field positions and the
// instruction-length rule. Optional build macro: FETCH_RESET_VECTOR_EN (used by fetch_unit).
package fetch_unit_pkg;

   typedef enum logic [2:0] {
      ST_OPCODE,
      ST_OPER1,
      ST_OPER2,
      ST_HOLD,
      ST_VEC_LO,
      ST_VEC_HI
   } fetch_state_t;

   // Opcode layout aaa_bbb_cc, shared with the decoder.
   localparam int AAA_MSB = 7;
   localparam int AAA_LSB = 5;
   localparam int BBB_MSB = 4;
   localparam int BBB_LSB = 2;
   localparam int CC_MSB  = 1;
   localparam int CC_LSB  = 0;

   function automatic logic [1:0] inst_len(input logic [7:0] opcode);
      logic [2:0] aaa;
      logic [2:0] bbb;
      logic [1:0] cc;
      logic [1:0] len;
      aaa = opcode[AAA_MSB:AAA_LSB];
      bbb = opcode[BBB_MSB:BBB_LSB];
      cc  = opcode[CC_MSB:CC_LSB];
      len = 2'd2;
      if (cc == 2'b11) begin
         len = 2'd1;
      end else begin
         case (bbb)
            3'b011, 3'b111: len = 2'd3;
            3'b001, 3'b101: len = 2'd2;
            3'b110:         len = (cc == 2'b01) ? 2'd3 : 2'd1;
            3'b010:         len = (cc == 2'b01) ? 2'd2 : 2'd1;
            3'b100:         len = (cc == 2'b10) ? 2'd1 : 2'd2;
            default: begin
               if (cc != 2'b00)
                  len = 2'd2;
               else if (aaa == 3'b001)
                  len = 2'd3;
               else if ((aaa == 3'b000) || (aaa == 3'b010) || (aaa == 3'b011))
                  len = 2'd1;
               else
                  len = 2'd2;
            end
         endcase
      end
      return len;
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: reads opcode plus 0-2 operand bytes over an 8-bit memory port and hands a whole
// instruction to the decoder. Optional build macro FETCH_RESET_VECTOR_EN loads the PC from memory.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [15:0] RESET_PC     = 16'h8000,
   parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   output logic        mem_req_o,
   output logic [15:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [7:0]  mem_rdata_i,
   input  logic        redirect_i,
   input  logic [15:0] redirect_pc_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [7:0]  opcode_o,
   output logic [15:0] data_o,
   output logic [15:0] pc_o,
   output logic [1:0]  len_o
);

`ifdef FETCH_RESET_VECTOR_EN
   localparam fetch_state_t RESET_STATE = ST_VEC_LO;
`else
   localparam fetch_state_t RESET_STATE = ST_OPCODE;
`endif

   fetch_state_t r_state;
   fetch_state_t w_nextState;

   logic [15:0] r_pc;
   logic [15:0] r_pcOut;
   logic [7:0]  r_opcode;
   logic [15:0] r_data;
   logic [1:0]  r_len;
   logic        r_pending;
   logic        r_stale;

   logic        w_reqWanted;
   logic [15:0] w_reqAddr;
   logic        w_grant;
   logic        w_accept;
   logic [1:0]  w_newLen;

   // A granted read that was orphaned by a redirect still blocks new requests until it returns.
   always_comb begin
      w_reqWanted = 1'b0;
      w_reqAddr   = r_pc;
      case (r_state)
         ST_OPCODE: begin
            w_reqWanted = 1'b1;
            w_reqAddr   = r_pc;
         end
         ST_OPER1: begin
            w_reqWanted = 1'b1;
            w_reqAddr   = r_pc + 16'd1;
         end
         ST_OPER2: begin
            w_reqWanted = 1'b1;
            w_reqAddr   = r_pc + 16'd2;
         end
         ST_VEC_LO: begin
            w_reqWanted = 1'b1;
            w_reqAddr   = RESET_VECTOR;
         end
         ST_VEC_HI: begin
            w_reqWanted = 1'b1;
            w_reqAddr   = RESET_VECTOR + 16'd1;
         end
         default: begin
            w_reqWanted = 1'b0;
            w_reqAddr   = r_pc;
         end
      endcase
   end

   assign mem_req_o  = rstn_i & w_reqWanted & ~r_pending;
   assign mem_addr_o = mem_req_o ? w_reqAddr : 16'h0000;
   assign w_grant    = mem_req_o & mem_gnt_i;
   assign w_accept   = mem_rvalid_i & r_pending & ~r_stale;
   assign w_newLen   = inst_len(mem_rdata_i);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         r_state <= RESET_STATE;
      else
         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      if (redirect_i) begin
         w_nextState = ST_OPCODE;
      end else begin
         case (r_state)
            ST_OPCODE: if (w_accept) w_nextState = (w_newLen == 2'd1) ? ST_HOLD : ST_OPER1;
            ST_OPER1:  if (w_accept) w_nextState = (r_len == 2'd2) ? ST_HOLD : ST_OPER2;
            ST_OPER2:  if (w_accept) w_nextState = ST_HOLD;
            ST_HOLD:   if (ready_i)  w_nextState = ST_OPCODE;
            ST_VEC_LO: if (w_accept) w_nextState = ST_VEC_HI;
            ST_VEC_HI: if (w_accept) w_nextState = ST_OPCODE;
            default:   w_nextState = ST_OPCODE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_pc      <= RESET_PC;
         r_pcOut   <= 16'h0000;
         r_opcode  <= 8'h00;
         r_data    <= 16'h0000;
         r_len     <= 2'd0;
         r_pending <= 1'b0;
         r_stale   <= 1'b0;
      end else begin
         r_pending <= w_grant | (r_pending & ~mem_rvalid_i);
         if (redirect_i)
            r_stale <= w_grant | (r_pending & ~mem_rvalid_i);
         else if (mem_rvalid_i & r_pending)
            r_stale <= 1'b0;

         if (redirect_i) begin
            r_pc   <= redirect_pc_i;
            r_data <= 16'h0000;
         end else begin
            case (r_state)
               ST_OPCODE: if (w_accept) begin
                  r_opcode <= mem_rdata_i;
                  r_len    <= w_newLen;
                  r_pcOut  <= r_pc;
                  r_data   <= 16'h0000;
               end
               ST_OPER1:  if (w_accept) r_data[15:8] <= mem_rdata_i;
               ST_OPER2:  if (w_accept) r_data[7:0]  <= mem_rdata_i;
               ST_HOLD:   if (ready_i)  r_pc <= r_pc + {14'd0, r_len};
               ST_VEC_LO: if (w_accept) r_pc[7:0]    <= mem_rdata_i;
               ST_VEC_HI: if (w_accept) r_pc[15:8]   <= mem_rdata_i;
               default: ;
            endcase
         end
      end
   end

   assign valid_o  = (r_state == ST_HOLD);
   assign opcode_o = r_opcode;
   assign data_o   = r_data;
   assign pc_o     = r_pcOut;
   assign len_o    = r_len;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run scored against
// an instruction-level memory model. Honours FETCH_RESET_VECTOR_EN when defined.
module tb_fetch_unit;

   logic        clk_i;
   logic        rstn_i;
   logic        mem_req_o;
   logic [15:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [7:0]  mem_rdata_i;
   logic        redirect_i;
   logic [15:0] redirect_pc_i;
   logic        valid_o;
   logic        ready_i;
   logic [7:0]  opcode_o;
   logic [15:0] data_o;
   logic [15:0] pc_o;
   logic [1:0]  len_o;

   fetch_unit dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .valid_o(valid_o), .ready_i(ready_i), .opcode_o(opcode_o), .data_o(data_o),
      .pc_o(pc_o), .len_o(len_o)
   );

`ifdef FETCH_RESET_VECTOR_EN
   localparam int VEC_LAT = 4;
`else
   localparam int VEC_LAT = 0;
`endif

   logic [7:0]  mem [0:65535];
   logic [15:0] grantLog [$];
   int          lenTab [4][8];
   int          gntPct = 100;
   int          minDelay = 0;
   int          maxDelay = 0;
   bit          spurEn = 1'b0;
   int          protoViol = 0;
   int          nCompared = 0;
   int          nMismatched = 0;

   // Clock.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Memory responder: grants with configurable probability, returns data after a random delay,
   // optionally injects rvalid pulses when nothing is outstanding.
   initial begin
      bit          respBusy;
      bit          wasBusy;
      int          respDelay;
      logic [15:0] respAddr;
      respBusy = 1'b0;
      respDelay = 0;
      respAddr = 16'h0;
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i = 8'h00;
      forever begin
         @(negedge clk_i);
         mem_gnt_i = 1'b0;
         mem_rvalid_i = 1'b0;
         if (!rstn_i) begin
            respBusy = 1'b0;
            continue;
         end
         wasBusy = respBusy;
         if (respBusy) begin
            if (respDelay == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i = mem[respAddr];
               respBusy = 1'b0;
            end else begin
               respDelay--;
            end
         end else if (spurEn && ($urandom_range(0, 7) == 0)) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = 8'($urandom);
         end
         if (mem_req_o) begin
            if (wasBusy) begin
               protoViol++;
            end else if (int'($urandom_range(0, 99)) < gntPct) begin
               mem_gnt_i = 1'b1;
               respAddr = mem_addr_o;
               respBusy = 1'b1;
               respDelay = int'($urandom_range(maxDelay, minDelay));
               grantLog.push_back(mem_addr_o);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive decoder-side inputs for one cycle, returning at the following negedge.
   task automatic applyStimulus(input logic rdy, input logic redir, input logic [15:0] target);
      ready_i = rdy;
      redirect_i = redir;
      redirect_pc_i = target;
      @(negedge clk_i);
      ready_i = 1'b0;
      redirect_i = 1'b0;
   endtask

   function automatic int refLen(input logic [7:0] op);
      int v;
      v = lenTab[op[1:0]][op[4:2]];
      if (v == 0) begin
         if (op[7:5] == 3'd1)
            v = 3;
         else if (op[7:5] == 3'd0 || op[7:5] == 3'd2 || op[7:5] == 3'd3)
            v = 1;
         else
            v = 2;
      end
      return v;
   endfunction

   function automatic logic [41:0] refInst(input logic [15:0] pc);
      logic [7:0]  op;
      logic [15:0] d;
      int          l;
      op = mem[pc];
      l = refLen(op);
      d = 16'h0000;
      if (l >= 2) d[15:8] = mem[pc + 16'd1];
      if (l == 3) d[7:0] = mem[pc + 16'd2];
      return {op, d, pc, 2'(l)};
   endfunction

   function automatic logic [41:0] dutInst();
      return {opcode_o, data_o, pc_o, len_o};
   endfunction

   task automatic doReset(input logic [7:0] vecHi);
      ready_i = 1'b0;
      redirect_i = 1'b0;
      rstn_i = 1'b0;
      #1;
      checkOutput("rst_valid", valid_o, 0);
      checkOutput("rst_req", mem_req_o, 0);
      checkOutput("rst_addr", mem_addr_o, 0);
      checkOutput("rst_opcode", opcode_o, 0);
      checkOutput("rst_data", data_o, 0);
      checkOutput("rst_pc", pc_o, 0);
      checkOutput("rst_len", len_o, 0);
      mem[16'hFFFC] = 8'h00;
      mem[16'hFFFD] = vecHi;
      repeat (2) @(negedge clk_i);
      grantLog.delete();
      @(posedge clk_i);
      #2;
      rstn_i = 1'b1;
   endtask

   task automatic waitValid(input int budget, output int lat);
      lat = 0;
      @(negedge clk_i);
      while (!valid_o && lat < budget) begin
         @(negedge clk_i);
         lat++;
      end
      checkOutput("valid_arrived", valid_o, 1);
   endtask

   task automatic waitGrant(input string tag, input logic [15:0] expAddr);
      int k;
      k = 0;
      while (grantLog.size() == 0 && k < 80) begin
         @(negedge clk_i);
         k++;
      end
      checkOutput({tag, "_seen"}, grantLog.size() > 0, 1);
      if (grantLog.size() > 0)
         checkOutput(tag, grantLog[0], expAddr);
   endtask

   task automatic setResponder(input int pct, input int dMin, input int dMax, input bit spur);
      gntPct = pct;
      minDelay = dMin;
      maxDelay = dMax;
      spurEn = spur;
   endtask

   initial begin
      int          lat;
      int          k;
      int          staleValid;
      int          nAcc;
      int          holdReq;
      logic [41:0] exp;
      logic [41:0] held;
      logic [15:0] pcModel;
      logic [15:0] tgt;
      logic        rdy;
      logic        redir;

      lenTab = '{'{0, 2, 1, 3, 2, 2, 1, 3},
                 '{2, 2, 2, 3, 2, 2, 3, 3},
                 '{2, 2, 1, 3, 1, 2, 1, 3},
                 '{1, 1, 1, 1, 1, 1, 1, 1}};
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      rstn_i = 1'b1;
      ready_i = 1'b0;
      redirect_i = 1'b0;
      redirect_pc_i = 16'h0000;
      @(negedge clk_i);

      // 2-byte instruction after reset, then sequential PC.
      setResponder(100, 0, 0, 1'b0);
      mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42; mem[16'h8002] = 8'hEA;
      doReset(8'h80);
      waitValid(60, lat);
      checkOutput("lat_2byte", lat, 4 + VEC_LAT);
      checkOutput("inst_A9", dutInst(), {8'hA9, 16'h4200, 16'h8000, 2'd2});
      grantLog.delete();
      applyStimulus(1'b1, 1'b0, 16'h0);
      waitGrant("next_8002", 16'h8002);

      // 3-byte instruction held under back-pressure.
      mem[16'h8000] = 8'h8D; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12; mem[16'h8003] = 8'hEA;
      doReset(8'h80);
      waitValid(60, lat);
      checkOutput("lat_3byte", lat, 6 + VEC_LAT);
      checkOutput("inst_8D", dutInst(), {8'h8D, 16'h3412, 16'h8000, 2'd3});
      held = dutInst();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0);
         checkOutput("hold_valid", valid_o, 1);
         checkOutput("hold_noreq", mem_req_o, 0);
         checkOutput("hold_stable", dutInst(), held);
      end
      grantLog.delete();
      applyStimulus(1'b1, 1'b0, 16'h0);
      waitGrant("next_8003", 16'h8003);

      // Redirect to FFFF, 1-byte instruction wraps PC to 0000, JSR there.
      mem[16'hFFFF] = 8'hEA; mem[16'h0000] = 8'h20; mem[16'h0001] = 8'hCD; mem[16'h0002] = 8'hAB;
      waitValid(60, lat);
      checkOutput("inst_8003", dutInst(), {8'hEA, 16'h0000, 16'h8003, 2'd1});
      grantLog.delete();
      applyStimulus(1'b0, 1'b1, 16'hFFFF);
      waitGrant("redir_FFFF", 16'hFFFF);
      waitValid(60, lat);
      checkOutput("inst_FFFF", dutInst(), {8'hEA, 16'h0000, 16'hFFFF, 2'd1});
      grantLog.delete();
      applyStimulus(1'b1, 1'b0, 16'h0);
      waitGrant("wrap_0000", 16'h0000);
      waitValid(60, lat);
      checkOutput("inst_JSR", dutInst(), {8'h20, 16'hCDAB, 16'h0000, 2'd3});

      // Redirect while the operand read of 8001 is outstanding.
      setResponder(100, 4, 4, 1'b0);
      mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42; mem[16'hC000] = 8'hEA;
      doReset(8'h80);
      k = 0;
      while (!(grantLog.size() > 0 && grantLog[$] == 16'h8001) && k < 100) begin
         @(negedge clk_i);
         k++;
      end
      checkOutput("oper_granted", grantLog[$], 16'h8001);
      @(negedge clk_i);
      applyStimulus(1'b0, 1'b1, 16'hC000);
      grantLog.delete();
      staleValid = 0;
      k = 0;
      while (grantLog.size() == 0 && k < 60) begin
         if (valid_o) staleValid++;
         @(negedge clk_i);
         k++;
      end
      checkOutput("no_stale_valid", staleValid, 0);
      waitGrant("redir_C000", 16'hC000);
      waitValid(60, lat);
      checkOutput("inst_C000", dutInst(), {8'hEA, 16'h0000, 16'hC000, 2'd1});

      // Redirect coinciding with the handshake.
      setResponder(100, 0, 0, 1'b0);
      mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42; mem[16'h1234] = 8'hEA;
      doReset(8'h80);
      waitValid(60, lat);
      grantLog.delete();
      applyStimulus(1'b1, 1'b1, 16'h1234);
      waitGrant("redir_hs", 16'h1234);
      waitValid(60, lat);
      checkOutput("inst_1234", dutInst(), {8'hEA, 16'h0000, 16'h1234, 2'd1});

`ifdef FETCH_RESET_VECTOR_EN
      // Reset vector fetch.
      mem[16'h9000] = 8'hEA;
      doReset(8'h90);
      staleValid = 0;
      k = 0;
      while (grantLog.size() < 3 && k < 60) begin
         @(negedge clk_i);
         if (valid_o) staleValid++;
         k++;
      end
      checkOutput("vec_nvalid", staleValid, 0);
      checkOutput("vec_count", grantLog.size() >= 3, 1);
      if (grantLog.size() >= 3) begin
         checkOutput("vec_lo", grantLog[0], 16'hFFFC);
         checkOutput("vec_hi", grantLog[1], 16'hFFFD);
         checkOutput("vec_op", grantLog[2], 16'h9000);
      end
      waitValid(60, lat);
      checkOutput("inst_9000", dutInst(), {8'hEA, 16'h0000, 16'h9000, 2'd1});
`endif

      // Randomized run scored against the instruction-level model.
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      setResponder(60, 0, 3, 1'b1);
      doReset(8'h80);
      pcModel = 16'h8000;
      nAcc = 0;
      holdReq = 0;
      @(negedge clk_i);
      for (int c = 0; c < 6000; c++) begin
         rdy = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 60) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
         if (valid_o && mem_req_o) holdReq++;
         if (valid_o && rdy) begin
            exp = refInst(pcModel);
            checkOutput("rand_inst", dutInst(), exp);
            pcModel = pcModel + {14'd0, exp[1:0]};
            nAcc++;
         end
         if (redir) pcModel = tgt;
         applyStimulus(rdy, redir, tgt);
      end
      checkOutput("rand_progress", nAcc > 150, 1);
      checkOutput("rand_hold_noreq", holdReq, 0);
      checkOutput("one_outstanding", protoViol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
